// File: rtl/uart_send_frame.sv
// ---------------------------------------------------------------------------
// uart_send_frame
//
// Purpose:
//   Serialises a BYTE_NUM-byte payload into a UART TX core one byte at a
//   time.  A rising edge on frame_en captures frame_data and starts a frame.
//   Each byte is offered with a uart_en request, held until the TX core
//   reports busy, and the next byte is loaded once the core goes idle again.
//   frame_done pulses for one cycle after the final byte.
//
// Optional feature:
//   UART_SEND_FRAME_CKSUM_EN - when defined, one extra byte is appended after
//   the payload: the modulo-256 sum of all payload bytes.
//
// Parameters:
//   BYTE_NUM   payload bytes, 1..8
//   MSB_FIRST  1: most-significant byte first, 0: least-significant first
//
// Ports:
//   sys_clk       in   system clock, rising edge
//   sys_rst_n     in   asynchronous active-low reset
//   frame_en      in   start request (rising edge starts a frame)
//   frame_data    in   payload, captured at frame start
//   frame_busy    out  high while a frame is in progress
//   frame_done    out  one-cycle pulse after the last byte
//   uart_en       out  byte-send request to the TX core
//   uart_din      out  byte presented to the TX core
//   uart_tx_busy  in   TX core busy flag
// ---------------------------------------------------------------------------
module uart_send_frame #(
    parameter int BYTE_NUM  = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  frame_en,
    input  logic [8*BYTE_NUM-1:0] frame_data,
    output logic                  frame_busy,
    output logic                  frame_done,
    output logic                  uart_en,
    output logic [7:0]            uart_din,
    input  logic                  uart_tx_busy
);

    localparam int W = 8 * BYTE_NUM;

    // byte_cnt value of the final byte of a frame
`ifdef UART_SEND_FRAME_CKSUM_EN
    localparam logic [3:0] LAST_CNT = 4'(BYTE_NUM);
`else
    localparam logic [3:0] LAST_CNT = 4'(BYTE_NUM - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic           en_d0_q, en_d1_q;
    logic [W-1:0]   shift_q, shift_d;
    logic [3:0]     byte_cnt_q, byte_cnt_d;
    logic           start_edge;
    logic [7:0]     head_byte;
    logic [W-1:0]   shift_adv;

    assign start_edge = en_d0_q & ~en_d1_q;

    // The byte on the send side of the shift register, and the register
    // advanced by one byte toward that side.
    assign head_byte = (MSB_FIRST != 0) ? shift_q[W-1 -: 8] : shift_q[7:0];
    assign shift_adv = (MSB_FIRST != 0) ? (shift_q << 8) : (shift_q >> 8);

`ifdef UART_SEND_FRAME_CKSUM_EN
    logic [7:0] cksum_q, cksum_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cksum_q <= 8'h00;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    // Once byte_cnt passes the payload the checksum byte is presented
    // instead of the (by then empty) shift register.
    assign uart_din = (byte_cnt_q == 4'(BYTE_NUM)) ? cksum_q : head_byte;
`else
    assign uart_din = head_byte;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            en_d0_q    <= 1'b0;
            en_d1_q    <= 1'b0;
            shift_q    <= '0;
            byte_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            en_d0_q    <= frame_en;
            en_d1_q    <= en_d0_q;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        frame_busy = 1'b1;
        frame_done = 1'b0;
        uart_en    = 1'b0;
`ifdef UART_SEND_FRAME_CKSUM_EN
        cksum_d    = cksum_q;
`endif
        case (state_q)
            IDLE: begin
                // Start edges are only honoured here, so edges arriving
                // mid-frame or during DONE are dropped.
                frame_busy = 1'b0;
                if (start_edge) begin
                    state_d    = LOAD;
                    shift_d    = frame_data;
                    byte_cnt_d = 4'd0;
`ifdef UART_SEND_FRAME_CKSUM_EN
                    cksum_d    = 8'h00;
`endif
                end
            end
            LOAD: begin
`ifdef UART_SEND_FRAME_CKSUM_EN
                if (byte_cnt_q < 4'(BYTE_NUM)) begin
                    cksum_d = cksum_q + head_byte;
                end
`endif
                state_d = REQ;
            end
            REQ: begin
                uart_en = 1'b1;
                if (uart_tx_busy) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (!uart_tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                shift_d    = shift_adv;
                byte_cnt_d = byte_cnt_q + 4'd1;
                state_d    = (byte_cnt_q == LAST_CNT) ? DONE : LOAD;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_send_frame.sv
module tb_uart_send_frame;

`ifdef UART_SEND_FRAME_CKSUM_EN
    localparam int CKB = 1;
`else
    localparam int CKB = 0;
`endif

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [2:0]  fen     = 3'b000;
    logic [31:0] fdata0  = 32'h0;
    logic [31:0] fdata1  = 32'h0;
    logic [7:0]  fdata2  = 8'h0;
    wire  [2:0]  fbusy, fdone, uen;
    wire  [7:0]  udin0, udin1, udin2;
    logic [2:0]  txbusy;

    always #5 sys_clk = ~sys_clk;

    uart_send_frame #(.BYTE_NUM(4), .MSB_FIRST(1)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst_n(rst_n), .frame_en(fen[0]), .frame_data(fdata0),
        .frame_busy(fbusy[0]), .frame_done(fdone[0]), .uart_en(uen[0]), .uart_din(udin0),
        .uart_tx_busy(txbusy[0]));
    uart_send_frame #(.BYTE_NUM(4), .MSB_FIRST(0)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst_n(rst_n), .frame_en(fen[1]), .frame_data(fdata1),
        .frame_busy(fbusy[1]), .frame_done(fdone[1]), .uart_en(uen[1]), .uart_din(udin1),
        .uart_tx_busy(txbusy[1]));
    uart_send_frame #(.BYTE_NUM(1), .MSB_FIRST(1)) u_dut2 (
        .sys_clk(sys_clk), .sys_rst_n(rst_n), .frame_en(fen[2]), .frame_data(fdata2),
        .frame_busy(fbusy[2]), .frame_done(fdone[2]), .uart_en(uen[2]), .uart_din(udin2),
        .uart_tx_busy(txbusy[2]));

    // TX core model: busy for blen cycles after accepting a request; in imm
    // mode busy also follows uart_en combinationally.
    int   blen [3] = '{10, 10, 10};
    logic [2:0] imm = 3'b000;
    int   txcnt [3] = '{0, 0, 0};

    always @(posedge sys_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n)                txcnt[k] <= 0;
            else if (txcnt[k] != 0)    txcnt[k] <= txcnt[k] - 1;
            else if (uen[k])           txcnt[k] <= blen[k];
        end
    end

    always_comb begin
        txbusy = 3'b000;
        for (int k = 0; k < 3; k++)
            txbusy[k] = (txcnt[k] != 0) | (imm[k] & uen[k]);
    end

    function automatic logic [7:0] din_of(input int k);
        case (k)
            0:       return udin0;
            1:       return udin1;
            default: return udin2;
        endcase
    endfunction

    // Byte logger: records uart_din on every rising uart_en, counts done pulses.
    logic [7:0] got [3][256];
    int   ngot  [3] = '{0, 0, 0};
    int   ndone [3] = '{0, 0, 0};
    logic [2:0] uen_prev = 3'b000;

    always @(negedge sys_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (uen[k] && !uen_prev[k]) begin
                got[k][ngot[k] % 256] <= din_of(k);
                ngot[k] <= ngot[k] + 1;
            end
            if (fdone[k]) ndone[k] <= ndone[k] + 1;
        end
        uen_prev <= uen;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_data(input int k, input logic [31:0] d);
        case (k)
            0:       fdata0 = d;
            1:       fdata1 = d;
            default: fdata2 = d[7:0];
        endcase
    endtask

    // Wait until ngot[k] reaches target, bounded.
    task automatic wait_bytes(input int k, input int target, input string nm);
        int c = 0;
        while (ngot[k] < target && c < 2000) begin
            @(negedge sys_clk); #1;
            c++;
        end
        chk({nm, "_wait"}, 64'(ngot[k] >= target), 64'd1);
    endtask

    task automatic wait_done(input int k, input int target, input string nm);
        int c = 0;
        while (ndone[k] < target && c < 3000) begin
            @(negedge sys_clk); #1;
            c++;
        end
        chk({nm, "_wait"}, 64'(ndone[k] >= target), 64'd1);
    endtask

    task automatic chk_bytes(input int k, input int base, input logic [0:7][7:0] exp,
                             input int n, input logic [7:0] ck, input string nm);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", nm, i), 64'(got[k][(base + i) % 256]), 64'(exp[i]));
        if (CKB != 0)
            chk($sformatf("%s_cksum", nm), 64'(got[k][(base + n) % 256]), 64'(ck));
    endtask

    typedef struct {
        int              idx;
        logic [31:0]     data;
        int              bl;
        logic            im;
        int              n;
        logic [0:7][7:0] exp;
        logic [7:0]      ck;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_g, base_d, nb, cyc, dcyc;
        logic seen;

        vecs[0] = '{0, 32'h1234ABCD, 10, 1'b0, 4, 64'h1234ABCD_00000000, 8'hBE};
        vecs[1] = '{1, 32'h1234ABCD, 10, 1'b0, 4, 64'hCDAB3412_00000000, 8'hBE};
        vecs[2] = '{0, 32'h01020304,  4, 1'b0, 4, 64'h01020304_00000000, 8'h0A};
        vecs[3] = '{0, 32'hFFFFFFFF,  3, 1'b0, 4, 64'hFFFFFFFF_00000000, 8'hFC};
        vecs[4] = '{2, 32'h0000005A,  5, 1'b1, 1, 64'h5A000000_00000000, 8'h5A};
        vecs[5] = '{1, 32'h89ABCDEF,  1, 1'b0, 4, 64'hEFCDAB89_00000000, 8'hF0};
        vecs[6] = '{2, 32'h000000C3,  1, 1'b0, 1, 64'hC3000000_00000000, 8'hC3};

        // Reset state
        repeat (3) @(negedge sys_clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy%0d", k), 64'(fbusy[k]), 64'd0);
            chk($sformatf("rst_done%0d", k), 64'(fdone[k]), 64'd0);
            chk($sformatf("rst_uen%0d", k),  64'(uen[k]),   64'd0);
            chk($sformatf("rst_din%0d", k),  64'(din_of(k)), 64'd0);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("idle_busy", 64'(fbusy), 64'd0);

        // Table-driven frames with latency and content checks
        for (int v = 0; v < 7; v++) begin
            int k;
            string nm;
            k  = vecs[v].idx;
            nm = $sformatf("vec%0d", v);
            blen[k] = vecs[v].bl;
            imm[k]  = vecs[v].im;
            set_data(k, vecs[v].data);
            nb = vecs[v].n + CKB;
            @(negedge sys_clk); #1;
            base_g = ngot[k];
            base_d = ndone[k];
            fen[k] = 1'b1;
            cyc = 0;
            seen = 1'b0;
            while (!seen && cyc < 3000) begin
                @(negedge sys_clk);
                cyc++;
                if (cyc == 1) chk({nm, "_busy_c1"}, 64'(fbusy[k]), 64'd0);
                if (cyc == 2) chk({nm, "_busy_c2"}, 64'(fbusy[k]), 64'd1);
                if (cyc == 3) fen[k] = 1'b0;
                if (fdone[k]) seen = 1'b1;
            end
            chk({nm, "_latency"}, 64'(cyc), 64'(2 + nb * (vecs[v].bl + 4)));
            repeat (3) @(negedge sys_clk);
            #1;
            chk({nm, "_busy_end"}, 64'(fbusy[k]), 64'd0);
            chk({nm, "_ndone"}, 64'(ndone[k] - base_d), 64'd1);
            chk({nm, "_nbytes"}, 64'(ngot[k] - base_g), 64'(nb));
            chk_bytes(k, base_g, vecs[v].exp, vecs[v].n, vecs[v].ck, nm);
            $display("vec%0d dut%0d data=%08h bytes=%0d latency=%0d", v, k, vecs[v].data, nb, cyc);
        end

        // Second start edge during byte 2 with new data: ignored
        blen[0] = 10; imm[0] = 1'b0;
        set_data(0, 32'h1234ABCD);
        @(negedge sys_clk); #1;
        base_g = ngot[0]; base_d = ndone[0];
        fen[0] = 1'b1;
        repeat (3) @(negedge sys_clk);
        fen[0] = 1'b0;
        wait_bytes(0, base_g + 2, "retrig");
        set_data(0, 32'h0);
        fen[0] = 1'b1;
        wait_done(0, base_d + 1, "retrig");
        repeat (6) @(negedge sys_clk); #1;
        chk("retrig_busy", 64'(fbusy[0]), 64'd0);
        chk("retrig_ndone", 64'(ndone[0] - base_d), 64'd1);
        chk("retrig_nbytes", 64'(ngot[0] - base_g), 64'(4 + CKB));
        chk_bytes(0, base_g, 64'h1234ABCD_00000000, 4, 8'hBE, "retrig");
        fen[0] = 1'b0;
        $display("retrig: frame sent with %0d bytes, %0d done pulses", ngot[0] - base_g, ndone[0] - base_d);

        // Start edge coinciding with DONE: ignored
        blen[0] = 2;
        set_data(0, 32'h89ABCDEF);
        repeat (3) @(negedge sys_clk); #1;
        base_g = ngot[0]; base_d = ndone[0];
        dcyc = 2 + (4 + CKB) * 6;
        fen[0] = 1'b1;
        cyc = 0;
        while (cyc < dcyc) begin
            @(negedge sys_clk);
            cyc++;
            if (cyc == 3) fen[0] = 1'b0;
            if (cyc == dcyc - 1) fen[0] = 1'b1;
        end
        chk("donecoll_done", 64'(fdone[0]), 64'd1);
        repeat (6) @(negedge sys_clk); #1;
        chk("donecoll_busy", 64'(fbusy[0]), 64'd0);
        chk("donecoll_ndone", 64'(ndone[0] - base_d), 64'd1);
        chk_bytes(0, base_g, 64'h89ABCDEF_00000000, 4, 8'hF0, "donecoll");
        fen[0] = 1'b0;
        $display("donecoll: edge in DONE, busy=%0b afterwards", fbusy[0]);

        // Reset during WAIT_HI of byte 3, frame_en held high through release
        blen[0] = 10;
        set_data(0, 32'h1234ABCD);
        repeat (3) @(negedge sys_clk); #1;
        base_g = ngot[0]; base_d = ndone[0];
        fen[0] = 1'b1;
        wait_bytes(0, base_g + 3, "midrst");
        repeat (3) @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_uen", 64'(uen[0]), 64'd0);
        chk("midrst_busy", 64'(fbusy[0]), 64'd0);
        chk("midrst_din", 64'(udin0), 64'd0);
        repeat (2) @(negedge sys_clk);
        #1;
        chk("midrst_nodone", 64'(ndone[0] - base_d), 64'd0);
        base_g = ngot[0]; base_d = ndone[0];
        rst_n = 1'b1;
        wait_done(0, base_d + 1, "restart");
        repeat (6) @(negedge sys_clk); #1;
        chk("restart_busy", 64'(fbusy[0]), 64'd0);
        chk("restart_ndone", 64'(ndone[0] - base_d), 64'd1);
        chk("restart_nbytes", 64'(ngot[0] - base_g), 64'(4 + CKB));
        chk_bytes(0, base_g, 64'h1234ABCD_00000000, 4, 8'hBE, "restart");
        fen[0] = 1'b0;
        $display("restart: %0d bytes after reset, first=%02h", ngot[0] - base_g, got[0][base_g % 256]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
